// File: rtl/alu_div_unit_pkg.sv
// rtl/alu_div_unit_pkg.sv - shared ALU encodings and divide unit state enumeration
package alu_div_unit_pkg;

    localparam logic [2:0] ALU_SEL_DIV = 3'b010;

    typedef enum logic [1:0] {
        CTRL_DIV  = 2'b00,
        CTRL_DIVU = 2'b01,
        CTRL_REM  = 2'b10,
        CTRL_REMU = 2'b11
    } div_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/alu_div_unit_div_step.sv
// rtl/alu_div_unit_div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          ge;

    // Partial remainder stays below the divisor, so the difference fits in XLEN bits.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        ge      = (shifted >= {1'b0, divisor_i});
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/alu_div_unit.sv
// rtl/alu_div_unit.sv - multi-cycle RV64M div/divu/rem/remu unit with valid/ready handshakes
module alu_div_unit
    import alu_div_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            sel_rem_q, sel_rem_d;
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] abs_a, abs_b, fix_val;
    logic            is_signed, a_neg, b_neg, fix_neg;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign is_signed = ~control[0];
    assign a_neg     = is_signed & op_a[XLEN-1];
    assign b_neg     = is_signed & op_b[XLEN-1];
    assign abs_a     = a_neg ? -op_a : op_a;
    assign abs_b     = b_neg ? -op_b : op_b;
    assign fix_val   = sel_rem_q ? rem_q : quo_q;
    assign fix_neg   = sel_rem_q ? rsign_q : qsign_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        sel_rem_d = sel_rem_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sel_rem_d = control[1];
                    cnt_d     = '0;
                    if (op_b == '0) begin
                        result_d = control[1] ? op_a : '1;
                        state_d  = ST_DONE;
                    end else if (is_signed && (op_a == MIN_INT) && (op_b == '1)) begin
                        result_d = control[1] ? '0 : op_a;
                        state_d  = ST_DONE;
                    end else begin
                        // Magnitudes go through the unsigned core; signs are reapplied in FIX.
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvsr_d  = abs_b;
                        qsign_d = a_neg ^ b_neg;
                        rsign_d = a_neg;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_neg ? -fix_val : fix_val;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            sel_rem_q <= 1'b0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            sel_rem_q <= sel_rem_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
        end
    end

endmodule
